pipe_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage CPU.
- Generates stall/flush for the PC, IF/ID, ID/EX and EX/MEM registers and selects the next-PC source.
- Covers load-use bubbles, taken branches, multi-cycle mult/div, synchronous exceptions (RI, syscall), eret and a level external interrupt.
- Owns the EXL flag, EPC and Cause state.

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard and exception controller for the 5-stage pipeline.
//
// Responsibilities:
//   - Generates stall/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
//   - Selects the next-PC source.
//   - Owns the EXL flag and the EPC and Cause registers.
//
// Ports:
//   clk, reset (async, active low)
//   id_rs/id_rt, id_uses_rs/id_uses_rt  : source operands of the instruction in ID
//   ex_*                                : class and status of the instruction in EX
//   int_req, int_en                     : level interrupt request and Status.IE
//   PC_Stall .. EX_MEM_Flush            : pipeline-register controls (combinational)
//   pc_sel                              : 0 seq, 1 branch target, 2 trap vector, 3 EPC
//   epc, cause, exl                     : exception state registers
//   md_busy                             : high while a mult/div holds EX
module pipe_hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_valid,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_wr_reg,
  input  logic        ex_branch_taken,
  input  logic        ex_md_start,
  input  logic        ex_syscall,
  input  logic        ex_eret,
  input  logic        ex_RI,
  input  logic [31:0] ex_pcplus4,
  input  logic        int_req,
  input  logic        int_en,
  output logic        PC_Stall,
  output logic        IF_ID_Stall,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Stall,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] epc,
  output logic [4:0]  cause,
  output logic        exl,
  output logic        md_busy
);

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;
  localparam logic [1:0] PC_EPC  = 2'd3;

  // The start cycle is the first of MD_CYCLES stall cycles.
  // The counter covers the remaining MD_CYCLES-1 cycles, then one release cycle follows.
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

  typedef enum logic [0:0] {RUN, MD_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       epc_d;
  logic [4:0]        cause_d;
  logic              exl_d;

  logic exc_hit, eret_hit, int_hit, br_hit, md_hit, lu_hit;

  // Hazard qualifiers, listed in priority order.
  assign exc_hit  = ex_valid & (ex_RI | ex_syscall);
  assign eret_hit = ex_valid & ex_eret;
  assign int_hit  = int_req & int_en & ~exl & ex_valid;
  assign br_hit   = ex_valid & ex_branch_taken;
  assign md_hit   = ex_valid & ex_md_start;
  assign lu_hit   = ex_MemRead & (ex_wr_reg != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_wr_reg)) |
                     (id_uses_rt & (id_rt == ex_wr_reg)));

  // State, counter and exception registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      epc     <= '0;
      cause   <= '0;
      exl     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc     <= epc_d;
      cause   <= cause_d;
      exl     <= exl_d;
    end
  end

  // Next state and pipeline controls; gated off while reset is asserted.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    epc_d        = epc;
    cause_d      = cause;
    exl_d        = exl;
    PC_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Stall  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    pc_sel       = PC_SEQ;
    md_busy      = 1'b0;

    if (reset) begin
      case (state_q)
        RUN: begin
          if (exc_hit) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            pc_sel       = PC_TRAP;
            epc_d        = ex_pcplus4 - 32'd4;
            cause_d      = ex_RI ? EXC_RI : EXC_SYS;
            exl_d        = 1'b1;
          end else if (eret_hit) begin
            // The eret itself still retires through MEM, so EX/MEM is kept.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            pc_sel      = PC_EPC;
            exl_d       = 1'b0;
          end else if (int_hit) begin
            // EPC points at the interrupted instruction so it re-executes after eret.
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Flush = 1'b1;
            pc_sel       = PC_TRAP;
            epc_d        = ex_pcplus4 - 32'd4;
            cause_d      = EXC_INT;
            exl_d        = 1'b1;
          end else if (br_hit) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            pc_sel      = PC_BR;
          end else if (md_hit) begin
            PC_Stall     = 1'b1;
            IF_ID_Stall  = 1'b1;
            ID_EX_Stall  = 1'b1;
            EX_MEM_Flush = 1'b1;
            cnt_d        = MD_LOAD;
            state_d      = MD_WAIT;
          end else if (lu_hit) begin
            PC_Stall    = 1'b1;
            IF_ID_Stall = 1'b1;
            ID_EX_Flush = 1'b1;
          end
        end
        MD_WAIT: begin
          // All other hazards are ignored here; a level interrupt simply stays pending.
          md_busy = 1'b1;
          if (cnt_q != '0) begin
            PC_Stall     = 1'b1;
            IF_ID_Stall  = 1'b1;
            ID_EX_Stall  = 1'b1;
            EX_MEM_Flush = 1'b1;
            cnt_d        = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_CYCLES = 4).
// Expected control vectors are queued when stimulus is applied and popped when sampled.
// Vector bit order: {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
//                    EX_MEM_Flush, pc_sel[1:0], md_busy}.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_valid, ex_MemRead;
  logic [4:0]  ex_wr_reg;
  logic        ex_branch_taken, ex_md_start, ex_syscall, ex_eret, ex_RI;
  logic [31:0] ex_pcplus4;
  logic        int_req, int_en;
  logic        PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush, EX_MEM_Flush;
  logic [1:0]  pc_sel;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic        exl, md_busy;

  pipe_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_valid(ex_valid), .ex_MemRead(ex_MemRead), .ex_wr_reg(ex_wr_reg),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .ex_syscall(ex_syscall), .ex_eret(ex_eret), .ex_RI(ex_RI), .ex_pcplus4(ex_pcplus4),
    .int_req(int_req), .int_en(int_en),
    .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Stall(ID_EX_Stall), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .pc_sel(pc_sel), .epc(epc), .cause(cause), .exl(exl), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] C_NONE = 9'b000_000_00_0;
  localparam logic [8:0] C_LU   = 9'b110_010_00_0;
  localparam logic [8:0] C_EXC  = 9'b001_011_10_0;
  localparam logic [8:0] C_ERET = 9'b001_010_11_0;
  localparam logic [8:0] C_BR   = 9'b001_010_01_0;
  localparam logic [8:0] C_MD   = 9'b110_101_00_0;
  localparam logic [8:0] C_MDW  = 9'b110_101_00_1;
  localparam logic [8:0] C_MDR  = 9'b000_000_00_1;

  typedef struct {
    string      tag;
    logic [8:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_valid = 1'b0; ex_MemRead = 1'b0; ex_wr_reg = '0;
    ex_branch_taken = 1'b0; ex_md_start = 1'b0;
    ex_syscall = 1'b0; ex_eret = 1'b0; ex_RI = 1'b0; ex_pcplus4 = '0;
    int_req = 1'b0; int_en = 1'b0;
  endtask

  task automatic check_ctrl();
    exp_t       e;
    logic [8:0] act;
    act = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_Flush,
           EX_MEM_Flush, pc_sel, md_busy};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %b required a queued entry", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.ctrl) else begin
        n_fail++;
        $error("FAIL %s: got %b required %b", e.tag, act, e.ctrl);
      end
    end
  endtask

  // Queue the expectation, sample after settle, then advance one clock.
  task automatic step(input string tag, input logic [8:0] exp);
    sb.push_back('{tag: tag, ctrl: exp});
    #1;
    check_ctrl();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] e_epc,
                          input logic [4:0] e_cause, input logic e_exl);
    n_tests++;
    assert (epc === e_epc) else begin
      n_fail++; $error("FAIL %s.epc: got %h required %h", tag, epc, e_epc);
    end
    n_tests++;
    assert (cause === e_cause) else begin
      n_fail++; $error("FAIL %s.cause: got %0d required %0d", tag, cause, e_cause);
    end
    n_tests++;
    assert (exl === e_exl) else begin
      n_fail++; $error("FAIL %s.exl: got %b required %b", tag, exl, e_exl);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with an exception presented: controls and registers must stay zero.
    reset = 1'b0;
    idle();
    ex_valid = 1'b1; ex_syscall = 1'b1; ex_pcplus4 = 32'h44;
    #2;
    sb.push_back('{tag: "reset_ctrl", ctrl: C_NONE});
    #1;
    check_ctrl();
    @(posedge clk); #1;
    chk_regs("reset", 32'h0, 5'd0, 1'b0);
    idle();
    reset = 1'b1;

    // Load-use on rs, on rt, against $zero, and with the operand not read.
    ex_MemRead = 1'b1; ex_wr_reg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    step("lu_rs", C_LU);
    ex_wr_reg = 5'd0; id_rs = 5'd0;
    step("lu_zero", C_NONE);
    ex_wr_reg = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
    step("lu_rt", C_LU);
    id_uses_rt = 1'b0;
    step("lu_rt_unused", C_NONE);
    idle();

    // Mult/div: 4 stall cycles, then a release cycle; an interrupt raised meanwhile waits.
    ex_valid = 1'b1; ex_md_start = 1'b1; ex_pcplus4 = 32'h304;
    step("md_start", C_MD);
    int_req = 1'b1; int_en = 1'b1;
    step("md_wait1", C_MDW);
    step("md_wait2", C_MDW);
    step("md_wait3", C_MDW);
    step("md_release", C_MDR);
    chk_regs("md_no_int", 32'h0, 5'd0, 1'b0);
    ex_md_start = 1'b0;
    step("int_deferred", C_EXC);
    chk_regs("int_deferred", 32'h300, 5'd0, 1'b1);
    step("int_masked_exl", C_NONE);
    chk_regs("int_masked_exl", 32'h300, 5'd0, 1'b1);

    // Eret, then the interrupt scenario at 0x204.
    int_req = 1'b0; ex_eret = 1'b1;
    step("eret1", C_ERET);
    chk_regs("eret1", 32'h300, 5'd0, 1'b0);
    ex_eret = 1'b0; int_req = 1'b1; ex_pcplus4 = 32'h204;
    step("int_204", C_EXC);
    chk_regs("int_204", 32'h200, 5'd0, 1'b1);
    ex_pcplus4 = 32'h208;
    step("int_second", C_NONE);
    chk_regs("int_second", 32'h200, 5'd0, 1'b1);
    idle();

    // RI with syscall set, taken even with exl already set; RI wins the cause.
    ex_valid = 1'b1; ex_RI = 1'b1; ex_syscall = 1'b1; ex_pcplus4 = 32'h0000_0104;
    step("ri_sys", C_EXC);
    chk_regs("ri_sys", 32'h100, 5'd10, 1'b1);
    ex_RI = 1'b0; ex_pcplus4 = 32'h50;
    step("sys", C_EXC);
    chk_regs("sys", 32'h4C, 5'd8, 1'b1);
    ex_syscall = 1'b0; ex_eret = 1'b1;
    step("eret2", C_ERET);
    chk_regs("eret2", 32'h4C, 5'd8, 1'b0);
    idle();

    // Priority: exception over branch, branch over load-use.
    ex_valid = 1'b1; ex_branch_taken = 1'b1; ex_syscall = 1'b1; ex_pcplus4 = 32'h8;
    step("br_vs_sys", C_EXC);
    chk_regs("br_vs_sys", 32'h4, 5'd8, 1'b1);
    ex_syscall = 1'b0;
    ex_MemRead = 1'b1; ex_wr_reg = 5'd12; id_rs = 5'd12; id_uses_rs = 1'b1;
    step("br_vs_lu", C_BR);
    idle();
    ex_branch_taken = 1'b1;
    step("br_bubble", C_NONE);
    idle();

    // Eret beats a pending interrupt; interrupt needs int_en and a valid EX.
    ex_valid = 1'b1; ex_eret = 1'b1; int_req = 1'b1; int_en = 1'b1;
    step("eret_vs_int", C_ERET);
    chk_regs("eret_vs_int", 32'h4, 5'd8, 1'b0);
    ex_eret = 1'b0; int_en = 1'b0;
    step("int_disabled", C_NONE);
    int_en = 1'b1; ex_valid = 1'b0;
    step("int_bubble", C_NONE);
    chk_regs("int_bubble", 32'h4, 5'd8, 1'b0);
    idle();

    // Async reset in the middle of a mult/div wait, no clock edge needed.
    ex_valid = 1'b1; ex_md_start = 1'b1;
    step("md2_start", C_MD);
    step("md2_wait1", C_MDW);
    #2;
    reset = 1'b0;
    sb.push_back('{tag: "reset_mid_md", ctrl: C_NONE});
    #1;
    check_ctrl();
    chk_regs("reset_mid_md", 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    step("after_reset", C_NONE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
